mc_main_ctrl_v2: RTL and testbench

- Parametrised multicycle MIPS main controller FSM; successor to the fixed single-latency controller.
- Sits between the instruction register (opcode/funct) and the datapath muxes and write enables.
- Adds a memory ready/wait handshake on every memory access and a multi-cycle multiply with a configurable-latency counter.
- Adds an illegal-opcode trap with an optional halt mode, and fully defined outputs in every state (no X drive).

---
 rtl/mc_main_ctrl_v2_pkg.sv | 63 ++++++
 rtl/mc_main_ctrl_v2_if.sv | 41 ++++
 rtl/mc_main_ctrl_v2_lat_counter.sv | 38 +++
 rtl/mc_main_ctrl_v2.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_main_ctrl_v2.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_main_ctrl_v2_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state enum,
// opcode/funct values and the datapath mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_EXEC     = 5'd2,
    S_ALUWB    = 5'd3,
    S_ADDIEX   = 5'd4,
    S_ORIEX    = 5'd5,
    S_SLTIEX   = 5'd6,
    S_IMMWB    = 5'd7,
    S_BRANCH   = 5'd8,
    S_JUMP     = 5'd9,
    S_JAL      = 5'd10,
    S_MEMADR   = 5'd11,
    S_MEMREAD  = 5'd12,
    S_MEMWRITE = 5'd13,
    S_MEMWB    = 5'd14,
    S_MULEX    = 5'd15,
    S_TRAP     = 5'd16
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_MUL   = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

endpackage

// File: rtl/mc_main_ctrl_v2_if.sv
// Controller <-> instruction register / datapath bundle. The controller
// side is the master; the datapath side is the slave.
interface mc_main_ctrl_v2_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    opcode;
  logic [OP_W-1:0]    funct;
  logic               mem_ready;
  logic               mem_req;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               pc_write;
  logic               branch;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_src;
  logic [1:0]         mem_to_reg;
  logic [1:0]         reg_dst;
  logic               ori;
  logic               mul_start;
  logic               trap;
  logic [4:0]         state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_write, branch, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, reg_dst, ori,
           mul_start, trap, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_write, branch, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg, reg_dst, ori,
           mul_start, trap, state_o
  );
endinterface

// File: rtl/mc_main_ctrl_v2_lat_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of
// wrapping so a stray decrement can never restart a latency window.
module mc_lat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mc_main_ctrl_v2.sv
// Multicycle MIPS main controller with memory wait handshake, multi-cycle
// multiply and illegal-opcode trap. Outputs decode combinationally from state.
//   FETCH/DECODE      | instruction fetch (waits on mem_ready) / opcode dispatch
//   EXEC/ALUWB        | R-type execute (jr exits here) / rd writeback
//   ADDIEX/ORIEX/SLTIEX/IMMWB | immediate execute / rt writeback
//   BRANCH/JUMP/JAL   | beq compare, jump, jump-and-link to r31
//   MEMADR/MEMREAD/MEMWRITE/MEMWB | address calc, load/store wait, load writeback
//   MULEX/TRAP        | MUL_LAT-cycle multiply / illegal opcode
module mc_main_ctrl_v2
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int ALUOP_W   = 3,
  parameter int MUL_LAT   = 4,
  parameter bit TRAP_HALT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_main_ctrl_v2_if.master   bus
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  state_e state_q;
  state_e state_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  logic               mem_req_c;
  logic               iord_c;
  logic               mem_write_c;
  logic               ir_write_c;
  logic               pc_write_c;
  logic               branch_c;
  logic               reg_write_c;
  logic               alu_src_a_c;
  logic [1:0]         alu_src_b_c;
  logic [ALUOP_W-1:0] alu_op_c;
  logic [1:0]         pc_src_c;
  logic [1:0]         mem_to_reg_c;
  logic [1:0]         reg_dst_c;
  logic               ori_c;
  logic               mul_start_c;
  logic               trap_c;

  assign cnt_load = (state_q == S_DECODE) && (bus.opcode == OP_W'(OP_MUL));
  assign cnt_dec  = (state_q == S_MULEX);

  mc_lat_counter #(.WIDTH(CNT_W)) u_mul_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_W'(OP_RTYPE):                 state_d = S_EXEC;
          OP_W'(OP_ADDI), OP_W'(OP_ADDIU): state_d = S_ADDIEX;
          OP_W'(OP_ORI):                   state_d = S_ORIEX;
          OP_W'(OP_SLTI):                  state_d = S_SLTIEX;
          OP_W'(OP_BEQ):                   state_d = S_BRANCH;
          OP_W'(OP_J):                     state_d = S_JUMP;
          OP_W'(OP_JAL):                   state_d = S_JAL;
          OP_W'(OP_LW), OP_W'(OP_SW):      state_d = S_MEMADR;
          OP_W'(OP_MUL):                   state_d = S_MULEX;
          default:                         state_d = S_TRAP;
        endcase
      end
      S_EXEC:     state_d = (bus.funct == OP_W'(FN_JR)) ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_ADDIEX,
      S_ORIEX,
      S_SLTIEX:   state_d = S_IMMWB;
      S_IMMWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_MEMADR:   state_d = (bus.opcode == OP_W'(OP_SW)) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_MULEX:    if (cnt_zero) state_d = S_ALUWB;
      S_TRAP:     state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req_c    = 1'b0;
    iord_c       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_B;
    alu_op_c     = ALUOP_W'(ALUOP_ADD);
    pc_src_c     = PCSRC_ALU;
    mem_to_reg_c = M2R_ALUOUT;
    reg_dst_c    = RDST_RT;
    ori_c        = 1'b0;
    mul_start_c  = 1'b0;
    trap_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = bus.mem_ready;
        ir_write_c  = bus.mem_ready;
      end
      S_DECODE:   alu_src_b_c = SRCB_SHIMM;
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_W'(ALUOP_FUNCT);
        if (bus.funct == OP_W'(FN_JR)) begin
          pc_src_c   = PCSRC_REGA;
          pc_write_c = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = RDST_RD;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
      end
      S_ORIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_W'(ALUOP_OR);
        ori_c       = 1'b1;
      end
      S_SLTIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_W'(ALUOP_SLT);
      end
      S_IMMWB:    reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_W'(ALUOP_SUB);
        pc_src_c    = PCSRC_ALUOUT;
        branch_c    = 1'b1;
      end
      S_JUMP: begin
        pc_src_c   = PCSRC_JUMP;
        pc_write_c = 1'b1;
      end
      S_JAL: begin
        pc_src_c     = PCSRC_JUMP;
        pc_write_c   = 1'b1;
        reg_write_c  = 1'b1;
        reg_dst_c    = RDST_R31;
        mem_to_reg_c = M2R_PC;
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = M2R_MDR;
      end
      S_MULEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_W'(ALUOP_MUL);
        // counter only holds MUL_LOAD on the first MULEX cycle
        mul_start_c = (cnt_val == MUL_LOAD);
      end
      S_TRAP:     trap_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req    = mem_req_c   & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.pc_write   = pc_write_c  & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.mul_start  = mul_start_c & rst_n;
  assign bus.iord       = iord_c;
  assign bus.branch     = branch_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.ori        = ori_c;
  assign bus.trap       = trap_c;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_main_ctrl_v2.sv
// Directed bench: dut_a uses MUL_LAT=4/TRAP_HALT=0, dut_b MUL_LAT=1/TRAP_HALT=1.
module tb_mc_main_ctrl_v2;

  localparam int FETCH = 0, DECODE = 1, EXEC = 2, ALUWB = 3, ORIEX = 5,
                 IMMWB = 7, BRANCH = 8, JAL = 10, MEMADR = 11, MEMREAD = 12,
                 MEMWRITE = 13, MEMWB = 14, MULEX = 15, TRAP = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mc_main_ctrl_v2_if #(.OP_W(6), .ALUOP_W(3)) a_if ();
  mc_main_ctrl_v2_if #(.OP_W(6), .ALUOP_W(3)) b_if ();

  mc_main_ctrl_v2 #(.OP_W(6), .ALUOP_W(3), .MUL_LAT(4), .TRAP_HALT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.master));
  mc_main_ctrl_v2 #(.OP_W(6), .ALUOP_W(3), .MUL_LAT(1), .TRAP_HALT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.mem_ready = 1'b1; a_if.opcode = 6'h00; a_if.funct = 6'h20;
    b_if.mem_ready = 1'b1; b_if.opcode = 6'h00; b_if.funct = 6'h20;
    tick(); #1;
    chk("rst_state", a_if.state_o, FETCH);
    chk("rst_pc_write", a_if.pc_write, 0);
    chk("rst_ir_write", a_if.ir_write, 0);
    chk("rst_mem_req", a_if.mem_req, 0);

    // add, mem_ready tied high
    tick(); rst_n = 1'b1; #1;
    chk("add_fetch", a_if.state_o, FETCH);
    chk("add_fetch_pcw", a_if.pc_write, 1);
    chk("add_fetch_irw", a_if.ir_write, 1);
    chk("add_fetch_srcb", a_if.alu_src_b, 2'b01);
    tick(); #1;
    chk("add_decode", a_if.state_o, DECODE);
    chk("add_decode_srcb", a_if.alu_src_b, 2'b11);
    chk("add_decode_rw", a_if.reg_write, 0);
    tick(); #1;
    chk("add_exec", a_if.state_o, EXEC);
    chk("add_exec_aluop", a_if.alu_op, 3'b010);
    chk("add_exec_srca", a_if.alu_src_a, 1);
    chk("add_exec_rw", a_if.reg_write, 0);
    tick(); #1;
    chk("add_aluwb", a_if.state_o, ALUWB);
    chk("add_aluwb_rw", a_if.reg_write, 1);
    chk("add_aluwb_rdst", a_if.reg_dst, 2'b01);
    chk("add_aluwb_m2r", a_if.mem_to_reg, 2'b00);

    // lw with 3 wait cycles in FETCH and 2 in MEMREAD
    tick(); a_if.opcode = 6'h23; a_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_fetch_wait", a_if.state_o, FETCH);
      chk("lw_fetch_wait_pcw", a_if.pc_write, 0);
      chk("lw_fetch_wait_irw", a_if.ir_write, 0);
      tick();
    end
    a_if.mem_ready = 1'b1; #1;
    chk("lw_fetch_rdy", a_if.state_o, FETCH);
    chk("lw_fetch_rdy_pcw", a_if.pc_write, 1);
    chk("lw_fetch_rdy_irw", a_if.ir_write, 1);
    tick(); #1;
    chk("lw_decode", a_if.state_o, DECODE);
    tick(); #1;
    chk("lw_memadr", a_if.state_o, MEMADR);
    chk("lw_memadr_srcb", a_if.alu_src_b, 2'b10);
    tick(); a_if.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lw_memread_wait", a_if.state_o, MEMREAD);
      chk("lw_memread_iord", a_if.iord, 1);
      chk("lw_memread_req", a_if.mem_req, 1);
      chk("lw_memread_pcw", a_if.pc_write, 0);
      chk("lw_memread_rw", a_if.reg_write, 0);
      tick();
    end
    a_if.mem_ready = 1'b1; #1;
    chk("lw_memread_rdy", a_if.state_o, MEMREAD);
    tick(); #1;
    chk("lw_memwb", a_if.state_o, MEMWB);
    chk("lw_memwb_m2r", a_if.mem_to_reg, 2'b01);
    chk("lw_memwb_rw", a_if.reg_write, 1);
    tick(); #1;
    chk("lw_done", a_if.state_o, FETCH);

    // sw with one wait cycle
    a_if.opcode = 6'h2b;
    tick(); tick(); tick(); a_if.mem_ready = 1'b0; #1;
    chk("sw_memwrite", a_if.state_o, MEMWRITE);
    chk("sw_memwrite_we", a_if.mem_write, 1);
    chk("sw_memwrite_rw", a_if.reg_write, 0);
    tick(); #1;
    chk("sw_memwrite_hold", a_if.state_o, MEMWRITE);
    a_if.mem_ready = 1'b1;
    tick(); #1;
    chk("sw_done", a_if.state_o, FETCH);

    // mul, MUL_LAT=4
    a_if.opcode = 6'h1c;
    tick(); #1;
    chk("mul_decode", a_if.state_o, DECODE);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("mul_mulex", a_if.state_o, MULEX);
      chk("mul_start", a_if.mul_start, (i == 0) ? 1 : 0);
      chk("mul_aluop", a_if.alu_op, 3'b101);
    end
    tick(); #1;
    chk("mul_aluwb", a_if.state_o, ALUWB);
    tick(); #1;
    chk("mul_done", a_if.state_o, FETCH);

    // jr
    a_if.opcode = 6'h00; a_if.funct = 6'h08;
    tick(); tick(); #1;
    chk("jr_exec", a_if.state_o, EXEC);
    chk("jr_pcsrc", a_if.pc_src, 2'b11);
    chk("jr_pcw", a_if.pc_write, 1);
    tick(); #1;
    chk("jr_no_aluwb", a_if.state_o, FETCH);

    // jal
    a_if.opcode = 6'h03; a_if.funct = 6'h20;
    tick(); tick(); #1;
    chk("jal_state", a_if.state_o, JAL);
    chk("jal_rdst", a_if.reg_dst, 2'b10);
    chk("jal_m2r", a_if.mem_to_reg, 2'b10);
    chk("jal_rw", a_if.reg_write, 1);
    chk("jal_pcsrc", a_if.pc_src, 2'b10);
    tick(); #1;
    chk("jal_done", a_if.state_o, FETCH);

    // beq
    a_if.opcode = 6'h04;
    tick(); tick(); #1;
    chk("beq_state", a_if.state_o, BRANCH);
    chk("beq_branch", a_if.branch, 1);
    chk("beq_pcsrc", a_if.pc_src, 2'b01);
    chk("beq_aluop", a_if.alu_op, 3'b001);
    chk("beq_pcw", a_if.pc_write, 0);

    // ori
    a_if.opcode = 6'h0d;
    tick(); tick(); tick(); #1;
    chk("ori_state", a_if.state_o, ORIEX);
    chk("ori_flag", a_if.ori, 1);
    chk("ori_aluop", a_if.alu_op, 3'b011);
    tick(); #1;
    chk("ori_immwb", a_if.state_o, IMMWB);
    chk("ori_immwb_rw", a_if.reg_write, 1);
    chk("ori_immwb_rdst", a_if.reg_dst, 2'b00);

    // illegal opcode, non-halting trap
    a_if.opcode = 6'h3f;
    tick(); tick(); tick(); #1;
    chk("trap_a_state", a_if.state_o, TRAP);
    chk("trap_a_flag", a_if.trap, 1);
    tick(); #1;
    chk("trap_a_resume", a_if.state_o, FETCH);
    chk("trap_a_clear", a_if.trap, 0);

    // reset during the second MULEX cycle
    a_if.opcode = 6'h1c;
    tick(); tick(); tick(); #1;
    chk("rmul_second", a_if.state_o, MULEX);
    rst_n = 1'b0; #1;
    chk("rmul_state", a_if.state_o, FETCH);
    chk("rmul_pcw", a_if.pc_write, 0);
    chk("rmul_irw", a_if.ir_write, 0);
    chk("rmul_memreq", a_if.mem_req, 0);
    chk("rmul_mulstart", a_if.mul_start, 0);
    tick(); rst_n = 1'b1; #1;
    chk("rmul_fetch_pcw", a_if.pc_write, 1);
    tick(); #1;
    chk("rmul_decode", a_if.state_o, DECODE);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("rmul_mulex", a_if.state_o, MULEX);
      chk("rmul_start", a_if.mul_start, (i == 0) ? 1 : 0);
    end
    tick(); #1;
    chk("rmul_aluwb", a_if.state_o, ALUWB);

    // dut_b: MUL_LAT=1 and halting trap
    rst_n = 1'b0; b_if.opcode = 6'h1c; #1;
    chk("b_rst_state", b_if.state_o, FETCH);
    chk("b_rst_pcw", b_if.pc_write, 0);
    tick(); rst_n = 1'b1; tick(); #1;
    chk("b_mul_decode", b_if.state_o, DECODE);
    tick(); #1;
    chk("b_mul_mulex", b_if.state_o, MULEX);
    chk("b_mul_start", b_if.mul_start, 1);
    tick(); #1;
    chk("b_mul_aluwb", b_if.state_o, ALUWB);
    b_if.opcode = 6'h3f;
    tick(); tick(); tick(); #1;
    chk("b_trap_state", b_if.state_o, TRAP);
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      chk("b_trap_halt", b_if.state_o, TRAP);
      chk("b_trap_flag", b_if.trap, 1);
    end
    rst_n = 1'b0; #1;
    chk("b_trap_rst", b_if.state_o, FETCH);
    chk("b_trap_rst_flag", b_if.trap, 0);
    tick(); rst_n = 1'b1; b_if.opcode = 6'h00; #1;
    chk("b_trap_release", b_if.state_o, FETCH);
    tick(); #1;
    chk("b_trap_release_dec", b_if.state_o, DECODE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
